// File: rtl/xfer_pkg.sv
// Shared definitions for the transfer-register adder stage:
// op codes, FSM states, adder selects and default widths.
package xfer_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CNT_W = 8;

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_PASS    = 3'd1;
    localparam logic [2:0] OP_INC     = 3'd2;
    localparam logic [2:0] OP_DEC     = 3'd3;
    localparam logic [2:0] OP_ADD     = 3'd4;
    localparam logic [2:0] OP_REP_INC = 3'd5;
    localparam logic [2:0] OP_REP_DEC = 3'd6;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    typedef enum logic [1:0] {
        ADD_PASS,
        ADD_INC,
        ADD_DEC,
        ADD_OFF
    } add_sel_t;

endpackage

// File: rtl/xfer_add16.sv
// Combinational modulo-2^WIDTH adder for pass/inc/dec/signed offset,
// with a flag for crossing the all-ones/zero boundary.
module xfer_add16
    import xfer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] value,
    input  add_sel_t         sel,
    input  logic [7:0]       offset,
    output logic [WIDTH-1:0] next,
    output logic             wrap
);

    logic [WIDTH:0] ext;
    logic [WIDTH:0] addend;

    assign addend = {1'b0, {(WIDTH-8){offset[7]}}, offset};

    always_comb begin
        ext  = {1'b0, value};
        wrap = 1'b0;
        unique case (sel)
            ADD_PASS: ext = {1'b0, value};
            ADD_INC: begin
                ext  = {1'b0, value} + (WIDTH+1)'(1);
                wrap = ext[WIDTH];
            end
            ADD_DEC: begin
                ext  = {1'b0, value} - (WIDTH+1)'(1);
                wrap = ext[WIDTH];
            end
            ADD_OFF: begin
                // a negative offset borrows exactly when the sum has no carry
                ext  = {1'b0, value} + addend;
                wrap = offset[7] ? ~ext[WIDTH] : ext[WIDTH];
            end
            default: ext = {1'b0, value};
        endcase
    end

    assign next = ext[WIDTH-1:0];

endmodule

// File: rtl/xfer_adder_unit.sv
// Address/write-back adder with a repeat sequencer for block ops.
// Optional wrap output enabled by XFER_ADDER_WRAP_FLAG_EN.
module xfer_adder_unit
    import xfer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] xfer_in,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [7:0]       offset,
    input  logic [CNT_W-1:0] rep_count,
    output logic [WIDTH-1:0] addr_out,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             wb_en,
`ifdef XFER_ADDER_WRAP_FLAG_EN
    output logic             wrap,
`endif
    output logic             busy
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] ptr, ptr_nxt;
    logic [CNT_W-1:0] remain, remain_nxt;
    logic             dir, dir_nxt;
    logic [WIDTH-1:0] addr_nxt, res_nxt;
    logic             rv_nxt, wb_nxt;

    logic [WIDTH-1:0] src, sum;
    add_sel_t         sel;
    logic             sum_wrap;

    assign busy = (state == ST_RUN);

    // while running the pointer feeds itself; the bus is ignored
    always_comb begin
        src = busy ? ptr : xfer_in;
        sel = ADD_PASS;
        if (busy) begin
            sel = dir ? ADD_DEC : ADD_INC;
        end else begin
            unique case (op)
                OP_INC:     sel = ADD_INC;
                OP_DEC:     sel = ADD_DEC;
                OP_ADD:     sel = ADD_OFF;
                OP_REP_INC: sel = (rep_count == '0) ? ADD_PASS : ADD_INC;
                OP_REP_DEC: sel = (rep_count == '0) ? ADD_PASS : ADD_DEC;
                default:    sel = ADD_PASS;
            endcase
        end
    end

    xfer_add16 #(.WIDTH(WIDTH)) u_add (
        .value  (src),
        .sel    (sel),
        .offset (offset),
        .next   (sum),
        .wrap   (sum_wrap)
    );

    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        remain_nxt = remain;
        dir_nxt    = dir;
        addr_nxt   = addr_out;
        res_nxt    = result;
        rv_nxt     = 1'b0;
        wb_nxt     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (op_valid) begin
                    unique case (op)
                        OP_PASS: begin
                            addr_nxt = xfer_in;
                            res_nxt  = sum;
                            rv_nxt   = 1'b1;
                        end
                        OP_INC, OP_DEC, OP_ADD: begin
                            addr_nxt = xfer_in;
                            res_nxt  = sum;
                            rv_nxt   = 1'b1;
                            wb_nxt   = 1'b1;
                        end
                        OP_REP_INC, OP_REP_DEC: begin
                            addr_nxt = xfer_in;
                            res_nxt  = sum;
                            rv_nxt   = 1'b1;
                            if (rep_count != '0) begin
                                wb_nxt     = 1'b1;
                                ptr_nxt    = sum;
                                remain_nxt = rep_count - CNT_W'(1);
                                dir_nxt    = (op == OP_REP_DEC);
                                if (rep_count > CNT_W'(1))
                                    state_nxt = ST_RUN;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                addr_nxt   = ptr;
                res_nxt    = sum;
                rv_nxt     = 1'b1;
                wb_nxt     = 1'b1;
                ptr_nxt    = sum;
                remain_nxt = remain - CNT_W'(1);
                if (remain == CNT_W'(1))
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            ptr          <= '0;
            remain       <= '0;
            dir          <= 1'b0;
            addr_out     <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            wb_en        <= 1'b0;
        end else begin
            state        <= state_nxt;
            ptr          <= ptr_nxt;
            remain       <= remain_nxt;
            dir          <= dir_nxt;
            addr_out     <= addr_nxt;
            result       <= res_nxt;
            result_valid <= rv_nxt;
            wb_en        <= wb_nxt;
        end
    end

`ifdef XFER_ADDER_WRAP_FLAG_EN
    always_ff @(posedge clk) begin
        if (rst)
            wrap <= 1'b0;
        else
            wrap <= rv_nxt & sum_wrap;
    end
`else
    logic unused_wrap;
    assign unused_wrap = sum_wrap;
`endif

endmodule

// File: tb/tb_xfer_adder_unit.sv
// Scoreboard bench for xfer_adder_unit; wrap is checked when
// XFER_ADDER_WRAP_FLAG_EN is defined.
module tb_xfer_adder_unit;
    import xfer_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] xfer_in = '0;
    logic        op_valid = 1'b0;
    logic [2:0]  op = '0;
    logic [7:0]  offset = '0;
    logic [7:0]  rep_count = '0;
    logic [15:0] addr_out, result;
    logic        result_valid, wb_en, busy;
`ifdef XFER_ADDER_WRAP_FLAG_EN
    logic        wrap;
`endif

    always #5 clk = ~clk;

    xfer_adder_unit dut (
        .clk          (clk),
        .rst          (rst),
        .xfer_in      (xfer_in),
        .op_valid     (op_valid),
        .op           (op),
        .offset       (offset),
        .rep_count    (rep_count),
        .addr_out     (addr_out),
        .result       (result),
        .result_valid (result_valid),
        .wb_en        (wb_en),
`ifdef XFER_ADDER_WRAP_FLAG_EN
        .wrap         (wrap),
`endif
        .busy         (busy)
    );

    typedef struct {
        logic [15:0] addr;
        logic [15:0] res;
        logic        wb;
        logic        wr;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int checks = 0;
    int errors = 0;
    int busy_cnt = 0;
    int run_len = 0;
    int max_run = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [2:0] o, input logic [15:0] x,
                                  input logic [7:0] off,
                                  output logic [15:0] nx, output logic wr);
        int s;
        s = int'(x);
        case (o)
            OP_INC, OP_REP_INC: s = s + 1;
            OP_DEC, OP_REP_DEC: s = s - 1;
            OP_ADD:             s = s + int'($signed(off));
            default: ;
        endcase
        wr = (s < 0) || (s > 65535);
        nx = s[15:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] o, input logic [15:0] x,
                        input logic [7:0] off, input logic [7:0] n);
        int k;
        logic [15:0] p, nx;
        logic wr;
        op_valid  = 1'b1;
        op        = o;
        xfer_in   = x;
        offset    = off;
        rep_count = n;
        k = 0;
        while (busy && k < 50) begin
            step();
            k++;
        end
        if (k == 50) check("busy_timeout", 1, 0);
        case (o)
            OP_PASS: sb.push_back('{x, x, 1'b0, 1'b0});
            OP_INC, OP_DEC, OP_ADD: begin
                model(o, x, off, nx, wr);
                sb.push_back('{x, nx, 1'b1, wr});
            end
            OP_REP_INC, OP_REP_DEC: begin
                if (n == 0) begin
                    sb.push_back('{x, x, 1'b0, 1'b0});
                end else begin
                    p = x;
                    for (int i = 0; i < int'(n); i++) begin
                        model(o, p, off, nx, wr);
                        sb.push_back('{p, nx, 1'b1, wr});
                        p = nx;
                    end
                end
            end
            default: ;
        endcase
        step();
        op_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (result_valid) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
            if (sb.size() == 0) begin
                check("spurious_valid", result_valid, 0);
            end else begin
                e = sb.pop_front();
                check("addr_out", addr_out, e.addr);
                check("result", result, e.res);
                check("wb_en", wb_en, e.wb);
`ifdef XFER_ADDER_WRAP_FLAG_EN
                check("wrap", wrap, e.wr);
`endif
            end
        end else begin
            run_len = 0;
            check("idle_wb", wb_en, 0);
`ifdef XFER_ADDER_WRAP_FLAG_EN
            check("idle_wrap", wrap, 0);
`endif
        end
    end

    initial begin
        repeat (2) step();
        @(negedge clk);
        check("rst_addr", addr_out, 0);
        check("rst_result", result, 0);
        check("rst_valid", result_valid, 0);
        check("rst_wb", wb_en, 0);
        check("rst_busy", busy, 0);
        step();
        rst = 1'b0;
        step();

        send(OP_INC, 16'h1234, 8'h00, 8'd0);
        step();
        @(negedge clk);
        check("inc_one_pulse", result_valid, 0);

        send(OP_DEC, 16'h0000, 8'h00, 8'd0);
        send(OP_ADD, 16'h0010, 8'h80, 8'd0);
        send(OP_ADD, 16'h7FF0, 8'h20, 8'd0);
        send(OP_ADD, 16'h0005, 8'hFE, 8'd0);
        send(OP_ADD, 16'h0001, 8'hFE, 8'd0);
        send(OP_INC, 16'hFFFF, 8'h00, 8'd0);
        send(OP_NOP, 16'h5555, 8'h00, 8'd0);
        send(3'd7, 16'h6666, 8'h00, 8'd0);
        repeat (3) step();

        busy_cnt = 0;
        send(OP_REP_INC, 16'h8000, 8'h00, 8'd3);
        op_valid = 1'b1;
        op       = OP_INC;
        xfer_in  = 16'h1111;
        step();
        op_valid = 1'b0;
        repeat (4) step();
        check("rep3_busy_cycles", busy_cnt, 2);

        busy_cnt = 0;
        send(OP_REP_DEC, 16'h4000, 8'h00, 8'd0);
        send(OP_REP_DEC, 16'h4000, 8'h00, 8'd1);
        repeat (3) step();
        check("rep01_busy_cycles", busy_cnt, 0);

        max_run = 0;
        send(OP_REP_INC, 16'h0100, 8'h00, 8'd2);
        send(OP_INC, 16'h0200, 8'h00, 8'd0);
        repeat (3) step();
        check("b2b_run_len", max_run, 3);
        send(OP_PASS, 16'hABCD, 8'h00, 8'd0);

        send(OP_REP_DEC, 16'h0001, 8'h00, 8'd3);
        repeat (5) step();

        busy_cnt = 0;
        send(OP_REP_INC, 16'h2000, 8'h00, 8'd5);
        step();
        rst = 1'b1;
        step();
        @(negedge clk);
        check("mid_rst_remaining", sb.size(), 3);
        check("mid_rst_valid", result_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_addr", addr_out, 0);
        sb.delete();
        step();
        rst = 1'b0;
        busy_cnt = 0;
        repeat (6) step();
        check("post_rst_busy", busy_cnt, 0);

        check("sb_drain", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
